// File: rtl/int_addsub_pipe.sv
// int_addsub_pipe -- pipelined integer add/subtract unit.
//
// The DATA_WIDTH-bit carry chain is cut into NUM_STAGES equal segments of
// SEG = DATA_WIDTH/NUM_STAGES bits. Stage k adds segment k using the carry
// registered by stage k-1. Operands and the partial sum travel down the pipe
// alongside. A valid/ready handshake with per-stage valid bits gives full
// throughput, backpressure and bubble collapsing.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand beat handshake
//   data_a, data_b      operands
//   op                  00 ADD, 01 ADC, 10 SUB, 11 SBB
//   carry_in            initial carry for ADC/SBB (SBB: 1 = no borrow)
//   sat_en              only with INT_ADDSUB_SATURATE_EN: clamp on signed overflow
//   out_valid/out_ready result beat handshake
//   sum                 result (saturated when enabled and overflowing)
//   carry_out           raw carry out of the MSB (SUB/SBB: 1 = no borrow)
//   overflow            signed overflow
//   zero, negative      flags of the final sum
//
// Build option: define INT_ADDSUB_SATURATE_EN to add the sat_en port.
// Requires DATA_WIDTH >= 2 and DATA_WIDTH a multiple of NUM_STAGES.

module int_addsub_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [1:0]            op,
  input  logic                  carry_in,
`ifdef INT_ADDSUB_SATURATE_EN
  input  logic                  sat_en,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  zero,
  output logic                  negative
);

  localparam int unsigned SEG  = DATA_WIDTH / NUM_STAGES;
  localparam int unsigned MSB  = DATA_WIDTH - 1;
  localparam int unsigned LAST = NUM_STAGES - 1;

  // Stage registers
  logic [NUM_STAGES-1:0] v_q;
  logic [DATA_WIDTH-1:0] a_q   [NUM_STAGES];
  logic [DATA_WIDTH-1:0] b_q   [NUM_STAGES];
  logic [DATA_WIDTH-1:0] s_q   [NUM_STAGES];
  logic                  c_q   [NUM_STAGES];
  logic                  sat_q [NUM_STAGES];
  logic                  ovf_q, zero_q, neg_q;

  // Inputs feeding each stage (port for stage 0, previous register otherwise)
  logic [DATA_WIDTH-1:0] a_src   [NUM_STAGES];
  logic [DATA_WIDTH-1:0] b_src   [NUM_STAGES];
  logic [DATA_WIDTH-1:0] s_src   [NUM_STAGES];
  logic                  c_src   [NUM_STAGES];
  logic                  sat_src [NUM_STAGES];
  logic                  vld_src [NUM_STAGES];

  // Next-state values
  logic [DATA_WIDTH-1:0] s_d [NUM_STAGES];
  logic                  c_d [NUM_STAGES];
  logic [DATA_WIDTH-1:0] sum_fin_d;
  logic                  ovf_d;

  logic [NUM_STAGES-1:0] ld, adv;

  // Handshake: resolved from the output backwards so a stage can load
  // in the same cycle its occupant moves on.
  always_comb begin
    adv = '0;
    ld  = '0;
    adv[LAST] = v_q[LAST] & out_ready;
    ld[LAST]  = ~v_q[LAST] | adv[LAST];
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      adv[LAST-i] = v_q[LAST-i] & ld[LAST-i+1];
      ld[LAST-i]  = ~v_q[LAST-i] | adv[LAST-i];
    end
  end

  assign in_ready = ld[0];

  // Stage inputs. Subtraction is A + ~B + c0.
  always_comb begin
    a_src[0]   = data_a;
    b_src[0]   = op[1] ? ~data_b : data_b;
    s_src[0]   = '0;
    c_src[0]   = op[0] ? carry_in : op[1];
`ifdef INT_ADDSUB_SATURATE_EN
    sat_src[0] = sat_en;
`else
    sat_src[0] = 1'b0;
`endif
    vld_src[0] = in_valid;
    for (int unsigned k = 1; k < NUM_STAGES; k++) begin
      a_src[k]   = a_q[k-1];
      b_src[k]   = b_q[k-1];
      s_src[k]   = s_q[k-1];
      c_src[k]   = c_q[k-1];
      sat_src[k] = sat_q[k-1];
      vld_src[k] = v_q[k-1];
    end
  end

  // Per-stage segment add, then overflow/saturation in the last stage.
  always_comb begin
    logic [SEG:0] seg;
    seg = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      seg = {1'b0, a_src[k][k*SEG +: SEG]} + {1'b0, b_src[k][k*SEG +: SEG]}
            + {{SEG{1'b0}}, c_src[k]};
      s_d[k] = s_src[k];
      s_d[k][k*SEG +: SEG] = seg[SEG-1:0];
      c_d[k] = seg[SEG];
    end
    ovf_d = (a_src[LAST][MSB] == b_src[LAST][MSB]) &&
            (s_d[LAST][MSB] != a_src[LAST][MSB]);
    sum_fin_d = s_d[LAST];
    if (sat_src[LAST] && ovf_d) begin
      sum_fin_d = a_src[LAST][MSB] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  // Data registers only load with a valid beat, so outputs hold their last
  // value while stalled or idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        sat_q[k] <= 1'b0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        if (ld[k]) begin
          v_q[k] <= vld_src[k];
        end
        if (ld[k] && vld_src[k]) begin
          a_q[k]   <= a_src[k];
          b_q[k]   <= b_src[k];
          s_q[k]   <= (k == LAST) ? sum_fin_d : s_d[k];
          c_q[k]   <= c_d[k];
          sat_q[k] <= sat_src[k];
        end
      end
      if (ld[LAST] && vld_src[LAST]) begin
        ovf_q  <= ovf_d;
        zero_q <= (sum_fin_d == '0);
        neg_q  <= sum_fin_d[MSB];
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign carry_out = c_q[LAST];
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

endmodule
